// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and control encodings.
// Used by the return-address stack and the control-unit decode.
package mips_pkg;

    localparam int RAS_DEPTH = 16;
    localparam int ADDR_W    = 32;

    localparam logic [1:0] J_NONE = 2'b00;
    localparam logic [1:0] J_JUMP = 2'b01;
    localparam logic [1:0] J_JS   = 2'b10;

    localparam logic [1:0] MTR_LINK = 2'b10;

    // JAL: a jump that also links PC+4 into the register file.
    function automatic logic ras_push(input logic [1:0] jump,
                                      input logic [1:0] mtr);
        return (jump == J_JUMP) && (mtr == MTR_LINK);
    endfunction

    // JS: jump through the saved return address.
    function automatic logic ras_pop(input logic [1:0] jump);
        return jump == J_JS;
    endfunction

endpackage

// File: rtl/ras_storage.sv
// Return-address storage array.
// One synchronous write port, one asynchronous read port.
module ras_storage #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 32,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [ADDR_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [ADDR_W-1:0] rdata
);

    logic [ADDR_W-1:0] mem [DEPTH];

    // Contents need no reset; Count gates every read.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/return_address_stack.sv
// Circular LIFO of return addresses for JAL/JS.
// Wraps and overwrites the oldest entry when full; sticky error flags.
module return_address_stack
    import mips_pkg::*;
#(
    parameter  int DEPTH  = RAS_DEPTH,
    parameter  int ADDR_W = mips_pkg::ADDR_W,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Enable,
    input  logic              Push,
    input  logic              Pop,
    input  logic              Flush,
    input  logic [ADDR_W-1:0] PushData,
    output logic [ADDR_W-1:0] PopData,
    output logic              Empty,
    output logic              Full,
    output logic [PTR_W:0]    Count,
    output logic              Overflow,
    output logic              Underflow
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0]  top;
    logic [PTR_W-1:0]  top_m1;
    logic [PTR_W-1:0]  top_next;
    logic [PTR_W:0]    count_next;
    logic              ovf_next;
    logic              unf_next;
    logic              push_e;
    logic              pop_e;
    logic              flush_e;
    logic              replace;
    logic [PTR_W-1:0]  wr_addr;
    logic [ADDR_W-1:0] rd_data;

    assign push_e  = Enable & Push & ~Flush;
    assign pop_e   = Enable & Pop & ~Flush;
    assign flush_e = Enable & Flush;

    assign Empty   = (Count == '0);
    assign Full    = (Count == FULL_CNT);
    assign top_m1  = top - PTR_W'(1);
    assign replace = push_e & pop_e & ~Empty;
    assign wr_addr = replace ? top_m1 : top;
    assign PopData = Empty ? '0 : rd_data;

    ras_storage #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .PTR_W  (PTR_W)
    ) u_storage (
        .clock (Clock),
        .we    (push_e),
        .waddr (wr_addr),
        .wdata (PushData),
        .raddr (top_m1),
        .rdata (rd_data)
    );

    // Next pointer/occupancy/flags; flush beats replace beats push beats pop.
    always_comb begin
        top_next   = top;
        count_next = Count;
        ovf_next   = Overflow;
        unf_next   = Underflow;
        priority case (1'b1)
            flush_e: begin
                top_next   = '0;
                count_next = '0;
                ovf_next   = 1'b0;
                unf_next   = 1'b0;
            end
            replace: begin
            end
            push_e: begin
                top_next = top + PTR_W'(1);
                if (Full) begin
                    ovf_next = 1'b1;
                end else begin
                    count_next = Count + 1'b1;
                end
            end
            pop_e: begin
                if (Empty) begin
                    unf_next = 1'b1;
                end else begin
                    top_next   = top_m1;
                    count_next = Count - 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Stack state register with asynchronous clear.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            top       <= '0;
            Count     <= '0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            top       <= top_next;
            Count     <= count_next;
            Overflow  <= ovf_next;
            Underflow <= unf_next;
        end
    end

endmodule

// File: tb/tb_return_address_stack.sv
// Self-checking bench for return_address_stack.
// Reference stack model kept in a queue; pops compare against it.
module tb_return_address_stack;

    localparam int DEPTH = 16;
    localparam int AW    = 32;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          Enable;
    logic          Push;
    logic          Pop;
    logic          Flush;
    logic [AW-1:0] PushData;
    logic [AW-1:0] PopData;
    logic          Empty;
    logic          Full;
    logic [4:0]    Count;
    logic          Overflow;
    logic          Underflow;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] want;

    return_address_stack #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Enable    (Enable),
        .Push      (Push),
        .Pop       (Pop),
        .Flush     (Flush),
        .PushData  (PushData),
        .PopData   (PopData),
        .Empty     (Empty),
        .Full      (Full),
        .Count     (Count),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        Enable   = 1'b1;
        Push     = 1'b0;
        Pop      = 1'b0;
        Flush    = 1'b0;
        PushData = '0;
    endtask

    task automatic model_push(input logic [AW-1:0] d);
        exp_q.push_back(d);
        if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
    endtask

    task automatic do_push(input logic [AW-1:0] d);
        Push = 1'b1;
        PushData = d;
        model_push(d);
        tick();
        idle();
    endtask

    task automatic do_flush();
        Flush = 1'b1;
        exp_q.delete();
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        Reset = 1'b0;
        tick();
        checks++;
        if (Count !== 5'd0 || Empty !== 1'b1 || Full !== 1'b0) begin
            errors++;
            $display("FAIL reset_occ got cnt=%0d e=%b f=%b want 0 1 0",
                     Count, Empty, Full);
        end
        checks++;
        if (Overflow !== 1'b0 || Underflow !== 1'b0 || PopData !== '0) begin
            errors++;
            $display("FAIL reset_flags got o=%b u=%b pd=%h want 0 0 0",
                     Overflow, Underflow, PopData);
        end
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_single_push();
        do_push(32'h0040_0004);
        checks++;
        if (PopData !== 32'h0040_0004 || Count !== 5'd1 || Empty !== 1'b0) begin
            errors++;
            $display("FAIL single_push got pd=%h cnt=%0d e=%b want 00400004 1 0",
                     PopData, Count, Empty);
        end
        Pop = 1'b1;
        #1;
        want = exp_q.pop_back();
        checks++;
        if (PopData !== want) begin
            errors++;
            $display("FAIL single_pop got %h want %h", PopData, want);
        end
        tick();
        idle();
    endtask

    task automatic test_lifo();
        do_push(32'h10);
        do_push(32'h20);
        do_push(32'h30);
        for (int i = 0; i < 3; i++) begin
            Pop = 1'b1;
            #1;
            want = exp_q.pop_back();
            checks++;
            if (PopData !== want) begin
                errors++;
                $display("FAIL lifo_pop%0d got %h want %h", i, PopData, want);
            end
            tick();
        end
        idle();
        checks++;
        if (Empty !== 1'b1 || PopData !== '0 || Underflow !== 1'b0) begin
            errors++;
            $display("FAIL lifo_end got e=%b pd=%h u=%b want 1 0 0",
                     Empty, PopData, Underflow);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 17; i++) do_push(AW'(i));
        checks++;
        if (Full !== 1'b1 || Count !== 5'd16 || Overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_state got f=%b cnt=%0d o=%b want 1 16 1",
                     Full, Count, Overflow);
        end
        for (int i = 0; i < 16; i++) begin
            Pop = 1'b1;
            #1;
            want = exp_q.pop_back();
            checks++;
            if (PopData !== want || PopData !== AW'(17 - i)) begin
                errors++;
                $display("FAIL ovf_pop%0d got %h want %h", i, PopData, want);
            end
            tick();
        end
        idle();
        checks++;
        if (Empty !== 1'b1 || Overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got e=%b o=%b want 1 1", Empty, Overflow);
        end
    endtask

    task automatic test_underflow_flush();
        Pop = 1'b1;
        #1;
        checks++;
        if (PopData !== '0) begin
            errors++;
            $display("FAIL unf_pd got %h want 0", PopData);
        end
        tick();
        idle();
        checks++;
        if (Underflow !== 1'b1 || Count !== 5'd0) begin
            errors++;
            $display("FAIL unf_set got u=%b cnt=%0d want 1 0", Underflow, Count);
        end
        do_flush();
        checks++;
        if (Underflow !== 1'b0 || Overflow !== 1'b0) begin
            errors++;
            $display("FAIL flush_clr got u=%b o=%b want 0 0", Underflow, Overflow);
        end
    endtask

    task automatic test_push_pop();
        Push = 1'b1;
        Pop = 1'b1;
        PushData = 32'h55;
        model_push(32'h55);
        tick();
        idle();
        checks++;
        if (Count !== 5'd1 || Underflow !== 1'b0 || PopData !== 32'h55) begin
            errors++;
            $display("FAIL pp_empty got cnt=%0d u=%b pd=%h want 1 0 55",
                     Count, Underflow, PopData);
        end
        do_flush();
        do_push(32'h11);
        do_push(32'h44);
        Push = 1'b1;
        Pop = 1'b1;
        PushData = 32'h88;
        #1;
        want = exp_q.pop_back();
        checks++;
        if (PopData !== want) begin
            errors++;
            $display("FAIL pp_pre got %h want %h", PopData, want);
        end
        exp_q.push_back(32'h88);
        tick();
        idle();
        checks++;
        if (Count !== 5'd2 || PopData !== exp_q[$]) begin
            errors++;
            $display("FAIL pp_replace got cnt=%0d pd=%h want 2 %h",
                     Count, PopData, exp_q[$]);
        end
    endtask

    task automatic test_stall_async_reset();
        Enable = 1'b0;
        Push = 1'b1;
        PushData = 32'h99;
        tick();
        Push = 1'b0;
        Flush = 1'b1;
        tick();
        idle();
        checks++;
        if (Count !== 5'd2 || PopData !== exp_q[$]) begin
            errors++;
            $display("FAIL stall got cnt=%0d pd=%h want 2 %h",
                     Count, PopData, exp_q[$]);
        end
        do_flush();
        Pop = 1'b1;
        tick();
        idle();
        do_push(32'hAA);
        checks++;
        if (Underflow !== 1'b1 || Count !== 5'd1) begin
            errors++;
            $display("FAIL pre_rst got u=%b cnt=%0d want 1 1", Underflow, Count);
        end
        Push = 1'b1;
        PushData = 32'hBB;
        #2;
        Reset = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if (Count !== 5'd0 || Underflow !== 1'b0 || Overflow !== 1'b0 ||
            Empty !== 1'b1 || PopData !== '0) begin
            errors++;
            $display("FAIL async_rst got cnt=%0d u=%b o=%b e=%b pd=%h want 0 0 0 1 0",
                     Count, Underflow, Overflow, Empty, PopData);
        end
        tick();
        checks++;
        if (Count !== 5'd0 || Empty !== 1'b1) begin
            errors++;
            $display("FAIL rst_hold got cnt=%0d e=%b want 0 1", Count, Empty);
        end
        idle();
        Reset = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_lifo();
        test_overflow();
        test_underflow_flush();
        test_push_pop();
        test_stall_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
